// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg
// Shared definitions for the run/step/halt sequencer:
//   - mode_e : processor execution mode, also driven out on the Mode port
//   - default debounce length and run-rate divider
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } mode_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int RUN_DIV_DEF         = 4;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Turns one raw, asynchronous push-button into a single one-cycle press pulse.
// The button is first brought into the clock domain by a 2-flop synchronizer.
// A counter then measures how long the synced level has stayed high. The pulse
// fires once, when the count reaches DEBOUNCE_CYCLES. The counter then saturates,
// so no further pulse can fire until the synced level drops and the count restarts.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   btn   in  raw button level (asynchronous)
//   press out one-cycle registered press pulse
module btn_debounce
  import exec_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             press_next_s;

  // Next count and press decision from the synchronized level
  always_comb begin
    cnt_next_s   = cnt_r;
    press_next_s = 1'b0;
    if (!sync2_r) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_next_s   = cnt_r + CNT_W'(1);
      // Fire only on the step into CNT_MAX. The counter then saturates, so a
      // long hold produces one pulse.
      press_next_s = (cnt_r == (CNT_MAX - CNT_W'(1)));
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Synchronizer, debounce counter and registered press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      cnt_r   <= cnt_next_s;
      press_r <= press_next_s;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/exec_step_controller.sv
// exec_step_controller
// Run/step/halt sequencer that produces a one-Clk-wide processor clock-enable.
// It supports these operations:
//   - free-run at Clk/RUN_DIV
//   - single-step
//   - manual halt
//   - PC breakpoint
// After every executed cycle it captures PC and write-back data for a display.
// Ports:
//   Clk, Reset                 clock, asynchronous active-low reset
//   BtnRun, BtnStep, BtnHalt   raw push-buttons (asynchronous)
//   BpEnable, BpAddr           breakpoint enable / PC
//   PC, WBWriteData            processor PC and write-back data
//   CpuEn                      processor clock-enable pulse
//   Mode                       0 HALT, 1 RUN, 2 STEP
//   CycleCount                 number of CpuEn pulses since reset (wraps)
//   DispA, DispB               latched PC[15:0] / WBWriteData[15:0]
//   BpHit                      sticky breakpoint-hit flag
module exec_step_controller
  import exec_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int RUN_DIV         = RUN_DIV_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnRun,
  input  logic        BtnStep,
  input  logic        BtnHalt,
  input  logic        BpEnable,
  input  logic [31:0] BpAddr,
  input  logic [31:0] PC,
  input  logic [31:0] WBWriteData,
  output logic        CpuEn,
  output logic [1:0]  Mode,
  output logic [31:0] CycleCount,
  output logic [15:0] DispA,
  output logic [15:0] DispB,
  output logic        BpHit
);

  localparam int               DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic run_pulse_s;
  logic step_pulse_s;
  logic halt_pulse_s;

  mode_e            state_r;
  mode_e            state_next_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic             first_r;
  logic             first_next_s;
  logic             cpu_en_r;
  logic             cpu_en_next_s;
  logic             en_d_r;
  logic             bp_hit_r;
  logic             bp_hit_next_s;
  logic [31:0]      cycle_count_r;
  logic [15:0]      disp_a_r;
  logic [15:0]      disp_b_r;
  logic             bp_match_s;
  logic             wb_hi_unused_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk   (Clk),
    .rst_n (Reset),
    .btn   (BtnRun),
    .press (run_pulse_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk   (Clk),
    .rst_n (Reset),
    .btn   (BtnStep),
    .press (step_pulse_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (
    .clk   (Clk),
    .rst_n (Reset),
    .btn   (BtnHalt),
    .press (halt_pulse_s)
  );

  // The breakpoint is ignored on the first issue after RUN starts, so
  // RUN from a breakpoint address executes past it.
  assign bp_match_s     = BpEnable && (PC == BpAddr) && !first_r;
  // Only the low half of the write-back data is displayed.
  assign wb_hi_unused_s = |WBWriteData[31:16];

  // Next-state, divider and issue decision for the sequencer
  always_comb begin
    state_next_s  = state_r;
    div_next_s    = div_r;
    first_next_s  = first_r;
    cpu_en_next_s = 1'b0;
    bp_hit_next_s = bp_hit_r;
    case (state_r)
      MODE_HALT: begin
        // Priority is halt > step > run. A halt pulse here is a no-op.
        if (halt_pulse_s) begin
          state_next_s = MODE_HALT;
        end else if (step_pulse_s) begin
          // Issue now so CpuEn lines up with the single STEP cycle.
          state_next_s  = MODE_STEP;
          cpu_en_next_s = 1'b1;
          first_next_s  = 1'b0;
          bp_hit_next_s = 1'b0;
        end else if (run_pulse_s) begin
          state_next_s  = MODE_RUN;
          div_next_s    = {DIV_W{1'b0}};
          first_next_s  = 1'b1;
          bp_hit_next_s = 1'b0;
        end else begin
          state_next_s = MODE_HALT;
        end
      end
      MODE_RUN: begin
        if (halt_pulse_s) begin
          state_next_s = MODE_HALT;
        end else if (div_r == DIV_LAST) begin
          div_next_s = {DIV_W{1'b0}};
          if (bp_match_s) begin
            state_next_s  = MODE_HALT;
            bp_hit_next_s = 1'b1;
          end else begin
            cpu_en_next_s = 1'b1;
            first_next_s  = 1'b0;
          end
        end else begin
          div_next_s = div_r + DIV_W'(1);
        end
      end
      MODE_STEP: begin
        state_next_s = MODE_HALT;
      end
      default: begin
        state_next_s = MODE_HALT;
      end
    endcase
  end

  // Sequencer state, divider, issue pulse, breakpoint flag and cycle counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r       <= MODE_HALT;
      div_r         <= {DIV_W{1'b0}};
      first_r       <= 1'b0;
      cpu_en_r      <= 1'b0;
      bp_hit_r      <= 1'b0;
      cycle_count_r <= 32'd0;
    end else begin
      state_r  <= state_next_s;
      div_r    <= div_next_s;
      first_r  <= first_next_s;
      cpu_en_r <= cpu_en_next_s;
      bp_hit_r <= bp_hit_next_s;
      if (cpu_en_next_s) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end
    end
  end

  // Display latches load one cycle after CpuEn, once the processor has advanced
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      en_d_r   <= 1'b0;
      disp_a_r <= 16'd0;
      disp_b_r <= 16'd0;
    end else begin
      en_d_r <= cpu_en_r;
      if (en_d_r) begin
        disp_a_r <= PC[15:0];
        disp_b_r <= WBWriteData[15:0];
      end
    end
  end

  assign CpuEn      = cpu_en_r;
  assign Mode       = state_r;
  assign CycleCount = cycle_count_r;
  assign DispA      = disp_a_r;
  assign DispB      = disp_b_r;
  assign BpHit      = bp_hit_r;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed bench for exec_step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=4).
// A scoreboard queue holds the CpuEn pulses the bench expects. For each pulse
// it records the CycleCount, Mode and absolute tick. A bench-side processor
// model advances PC by 4 after every CpuEn and sets WBWriteData = 0x1230 + PC.
module tb_exec_step_controller;

  typedef struct {
    int unsigned count;
    logic [1:0]  mode;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        BtnRun;
  logic        BtnStep;
  logic        BtnHalt;
  logic        BpEnable;
  logic [31:0] BpAddr;
  logic [31:0] PC;
  logic [31:0] WBWriteData;
  logic        CpuEn;
  logic [1:0]  Mode;
  logic [31:0] CycleCount;
  logic [15:0] DispA;
  logic [15:0] DispB;
  logic        BpHit;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   base;
  logic pc_pend = 1'b0;
  logic prev_en = 1'b0;

  exec_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(4)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .BtnRun      (BtnRun),
    .BtnStep     (BtnStep),
    .BtnHalt     (BtnHalt),
    .BpEnable    (BpEnable),
    .BpAddr      (BpAddr),
    .PC          (PC),
    .WBWriteData (WBWriteData),
    .CpuEn       (CpuEn),
    .Mode        (Mode),
    .CycleCount  (CycleCount),
    .DispA       (DispA),
    .DispB       (DispB),
    .BpHit       (BpHit)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int unsigned c, input logic [1:0] m, input int cy);
    exp_t e;
    e.count = c;
    e.mode  = m;
    e.cyc   = cy;
    sb_q.push_back(e);
  endtask

  // One clock: sample 1ns after the edge, advance the processor model and score CpuEn.
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    cyc++;
    if (pc_pend) begin
      PC          = PC + 32'd4;
      WBWriteData = 32'h0000_1230 + PC;
      pc_pend     = 1'b0;
    end
    if (CpuEn === 1'b1) begin
      check("cpuen_back_to_back", {31'd0, prev_en}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_cpuen", {31'd0, CpuEn}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("cycle_count_at_cpuen", CycleCount, e.count);
        check("mode_at_cpuen", {30'd0, Mode}, {30'd0, e.mode});
        check("cpuen_timing", cyc, e.cyc);
      end
      pc_pend = 1'b1;
    end
    prev_en = CpuEn;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpuen"}, {31'd0, CpuEn}, 32'd0);
    check({tag, "_mode"}, {30'd0, Mode}, 32'd0);
    check({tag, "_count"}, CycleCount, 32'd0);
    check({tag, "_dispa"}, {16'd0, DispA}, 32'd0);
    check({tag, "_dispb"}, {16'd0, DispB}, 32'd0);
    check({tag, "_bphit"}, {31'd0, BpHit}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; BtnRun = 1'b0; BtnStep = 1'b0; BtnHalt = 1'b0;
    BpEnable = 1'b0; BpAddr = 32'd0; PC = 32'd0; WBWriteData = 32'd0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals("in_reset");
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    check_reset_vals("after_release");

    // Single step: the button is held 10 cycles, and one CpuEn is expected.
    base = cyc;
    push(1, 2'd2, base + 7);
    BtnStep = 1'b1;
    repeat (10) tick();
    BtnStep = 1'b0;
    repeat (6) tick();
    check("step_count", CycleCount, 32'd1);
    check("step_mode", {30'd0, Mode}, 32'd0);
    check("step_dispa", {16'd0, DispA}, 32'h0000_0004);
    check("step_dispb", {16'd0, DispB}, 32'h0000_1234);

    // Free run, then halt pressed 40 cycles after run. The halt lands on a would-issue cycle.
    base = cyc;
    for (int i = 0; i < 9; i++) push(2 + i, 2'd1, base + 11 + 4 * i);
    BtnRun = 1'b1;
    repeat (6) tick();
    check("run_mode_before", {30'd0, Mode}, 32'd0);
    tick();
    check("run_mode_entered", {30'd0, Mode}, 32'd1);
    tick();
    BtnRun = 1'b0;
    repeat (32) tick();
    BtnHalt = 1'b1;
    repeat (8) tick();
    BtnHalt = 1'b0;
    repeat (8) tick();
    check("halt_mode", {30'd0, Mode}, 32'd0);
    check("halt_count", CycleCount, 32'd10);
    check("halt_dispa", {16'd0, DispA}, 32'h0000_0028);
    check("halt_dispb", {16'd0, DispB}, 32'h0000_1258);
    check("halt_sb_drain", sb_q.size(), 32'd0);

    // Breakpoint at 0x10, starting from a fresh reset with PC=0.
    @(negedge Clk);
    Reset = 1'b0; PC = 32'd0; WBWriteData = 32'd0; pc_pend = 1'b0; prev_en = 1'b0;
    repeat (2) tick();
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    BpEnable = 1'b1;
    BpAddr   = 32'h0000_0010;
    base = cyc;
    for (int i = 0; i < 4; i++) push(1 + i, 2'd1, base + 11 + 4 * i);
    BtnRun = 1'b1;
    repeat (8) tick();
    BtnRun = 1'b0;
    repeat (28) tick();
    check("bp_hit", {31'd0, BpHit}, 32'd1);
    check("bp_mode", {30'd0, Mode}, 32'd0);
    check("bp_count", CycleCount, 32'd4);
    check("bp_sb_drain", sb_q.size(), 32'd0);
    // Run again. BpHit clears, and the instruction at 0x10 executes.
    base = cyc;
    push(5, 2'd1, base + 11);
    push(6, 2'd1, base + 15);
    BtnRun = 1'b1;
    repeat (7) tick();
    check("bp_cleared", {31'd0, BpHit}, 32'd0);
    check("bp_rerun_mode", {30'd0, Mode}, 32'd1);
    repeat (5) tick();
    BtnRun  = 1'b0;
    BtnHalt = 1'b1;
    repeat (8) tick();
    BtnHalt = 1'b0;
    repeat (6) tick();
    check("bp_rerun_count", CycleCount, 32'd6);
    check("bp_rerun_mode_end", {30'd0, Mode}, 32'd0);
    check("bp_rerun_dispa", {16'd0, DispA}, 32'h0000_0018);
    check("bp_rerun_dispb", {16'd0, DispB}, 32'h0000_1248);

    // All three buttons together: halt wins, and nothing happens.
    BtnRun = 1'b1; BtnStep = 1'b1; BtnHalt = 1'b1;
    repeat (7) tick();
    check("all3_mode", {30'd0, Mode}, 32'd0);
    tick();
    BtnRun = 1'b0; BtnStep = 1'b0; BtnHalt = 1'b0;
    repeat (6) tick();
    check("all3_count", CycleCount, 32'd6);
    // Step and run together: step wins, with one CpuEn.
    base = cyc;
    push(7, 2'd2, base + 7);
    BtnRun = 1'b1; BtnStep = 1'b1;
    repeat (8) tick();
    BtnRun = 1'b0; BtnStep = 1'b0;
    repeat (6) tick();
    check("step_run_count", CycleCount, 32'd7);
    check("step_run_mode", {30'd0, Mode}, 32'd0);

    // Bouncing step button, then a 6-cycle hold: exactly one press.
    base = cyc;
    push(8, 2'd2, base + 16);
    for (int i = 0; i < 3; i++) begin
      BtnStep = 1'b1;
      repeat (2) tick();
      BtnStep = 1'b0;
      tick();
    end
    BtnStep = 1'b1;
    repeat (6) tick();
    BtnStep = 1'b0;
    repeat (8) tick();
    check("bounce_count", CycleCount, 32'd8);
    check("bounce_dispa", {16'd0, DispA}, 32'h0000_0020);
    check("bounce_sb_drain", sb_q.size(), 32'd0);

    // Asynchronous reset mid-RUN, applied in the middle of a CpuEn cycle.
    base = cyc;
    push(9, 2'd1, base + 11);
    push(10, 2'd1, base + 15);
    BtnRun = 1'b1;
    repeat (8) tick();
    BtnRun = 1'b0;
    repeat (7) tick();
    #2;
    Reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    PC = 32'd0; WBWriteData = 32'd0; pc_pend = 1'b0; prev_en = 1'b0;
    repeat (3) tick();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (20) tick();
    check("post_reset_mode", {30'd0, Mode}, 32'd0);
    check("post_reset_count", CycleCount, 32'd0);
    check("post_reset_sb_drain", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
